// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT output serializer slice.
package fft_pkg;

  localparam int unsigned DEFAULT_DATA_W  = 32;
  localparam int unsigned DEFAULT_LANES   = 8;
  localparam int unsigned DEFAULT_SCALE_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Width of one real or imaginary half of a complex word.
  function automatic int unsigned half_w(input int unsigned data_w);
    return data_w / 2;
  endfunction

endpackage

// File: rtl/fft_output_serializer_if.sv
// Group-in / word-out handshake bundle of the FFT output serializer.
interface fft_output_serializer_if
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned LANES   = DEFAULT_LANES,
  parameter int unsigned SCALE_W = DEFAULT_SCALE_W
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_W-1:0]   in_data;
  logic                      in_last;
  logic                      mode;
  logic [SCALE_W-1:0]        scale_shift;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;

  modport master (
    output in_valid, in_data, in_last, mode, scale_shift, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, mode, scale_shift, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/cplx_swap_scale.sv
// Optional real/imag swap followed by rounded, saturating right shift of
// both halves of one complex word.
module cplx_swap_scale
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned SCALE_W = DEFAULT_SCALE_W
) (
  input  logic [DATA_W-1:0]  in_word,
  input  logic               mode,
  input  logic [SCALE_W-1:0] scale_shift,
  output logic [DATA_W-1:0]  out_word
);
  localparam int unsigned HW = half_w(DATA_W);
  localparam logic signed [HW:0] HALF_MAX = {2'b00, {(HW-1){1'b1}}};

  // Round-half-up shift done one bit wider than a half so the rounding add
  // cannot wrap; only the positive side can exceed the half range.
  function automatic logic [HW-1:0] scale_half(input logic [HW-1:0] h,
                                               input logic [SCALE_W-1:0] s);
    logic signed [HW:0] ext;
    logic signed [HW:0] sum;
    logic signed [HW:0] r;
    ext = {h[HW-1], h};
    if (s == '0) return h;
    sum = ext + signed'((HW+1)'(1) << (s - SCALE_W'(1)));
    r   = sum >>> s;
    if (r > HALF_MAX) r = HALF_MAX;
    return r[HW-1:0];
  endfunction

  logic [HW-1:0] re_sw;
  logic [HW-1:0] im_sw;

  // Swap the halves when requested, then scale each independently.
  always_comb begin
    if (mode) begin
      re_sw = in_word[HW-1:0];
      im_sw = in_word[DATA_W-1:HW];
    end else begin
      re_sw = in_word[DATA_W-1:HW];
      im_sw = in_word[HW-1:0];
    end
    out_word = {scale_half(re_sw, scale_shift), scale_half(im_sw, scale_shift)};
  end
endmodule

// File: rtl/fft_output_serializer.sv
// Loads a processed group of LANES complex words in parallel and streams
// them out lane 0 first on a valid/ready port, with zero-bubble reload.
module fft_output_serializer
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned LANES   = DEFAULT_LANES,
  parameter int unsigned SCALE_W = DEFAULT_SCALE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  fft_output_serializer_if.slave  bus
);
  localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LANES - 1);

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          last_flag_q, last_flag_d;
  logic [LANES-1:0][DATA_W-1:0]  sr_q, sr_d;
  logic [LANES-1:0][DATA_W-1:0]  proc_w;

  logic at_last;
  logic in_ready_w;
  logic out_fire;
  logic load;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    cplx_swap_scale #(
      .DATA_W  (DATA_W),
      .SCALE_W (SCALE_W)
    ) u_lane (
      .in_word     (bus.in_data[k*DATA_W +: DATA_W]),
      .mode        (bus.mode),
      .scale_shift (bus.scale_shift),
      .out_word    (proc_w[k])
    );
  end

  // Handshake decode, next-state, shift and load selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_flag_d = last_flag_q;
    sr_d        = sr_q;

    at_last    = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    in_ready_w = (state_q == IDLE) || (at_last && bus.out_ready);
    out_fire   = (state_q == SHIFT) && bus.out_ready;
    load       = bus.in_valid && in_ready_w;

    if (out_fire) begin
      for (int unsigned k = 0; k < LANES - 1; k++) sr_d[k] = sr_q[k+1];
      sr_d[LANES-1] = '0;
      cnt_d         = cnt_q + CNT_W'(1);
      if (at_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end

    // A load overrides the final shift so the new lane 0 follows directly.
    if (load) begin
      sr_d        = proc_w;
      cnt_d       = '0;
      last_flag_d = bus.in_last;
      state_d     = SHIFT;
    end
  end

  // State, counter, frame flag and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_flag_q <= 1'b0;
      sr_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_flag_q <= last_flag_d;
      sr_q        <= sr_d;
    end
  end

  // Output port drive.
  always_comb begin
    bus.in_ready  = in_ready_w;
    bus.out_valid = (state_q == SHIFT);
    bus.out_data  = sr_q[0];
    bus.out_last  = last_flag_q && at_last;
  end
endmodule

// File: tb/tb_fft_output_serializer.sv
// Randomised and directed bench for fft_output_serializer against a
// queue-based reference of the emitted word stream.
module tb_fft_output_serializer;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LANES   = 8;
  localparam int unsigned SCALE_W = 3;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              l;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   err_cnt = 0;
  int   chk_cnt = 0;
  int   words_seen = 0;
  int   lasts_seen = 0;
  logic rand_ready = 1'b0;
  exp_t model_q[$];

  always #5 clk = ~clk;

  fft_output_serializer_if #(.DATA_W(DATA_W), .LANES(LANES), .SCALE_W(SCALE_W)) bus ();

  fft_output_serializer #(
    .DATA_W  (DATA_W),
    .LANES   (LANES),
    .SCALE_W (SCALE_W)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Rounded shift of one signed half, clamped to the largest positive half.
  function automatic int ref_half(input int v, input int s);
    int r;
    if (s == 0) return v;
    r = (v + (1 << (s - 1))) >>> s;
    if (r > 32767) r = 32767;
    return r;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] w, input logic m, input int s);
    int re, im, t;
    logic [15:0] a, b;
    re = int'($signed(w[31:16]));
    im = int'($signed(w[15:0]));
    if (m) begin t = re; re = im; im = t; end
    a = 16'(ref_half(re, s));
    b = 16'(ref_half(im, s));
    return {a, b};
  endfunction

  function automatic logic [15:0] rand_half();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Mid-cycle scoreboard: compare against the pending-word queue, then
  // advance the queue by what the coming edge will transfer.
  always @(negedge clk) begin
    logic exp_v, exp_rdy;
    if (rst) begin
      model_q.delete();
    end else begin
      exp_v   = (model_q.size() != 0);
      exp_rdy = (model_q.size() == 0) || (model_q.size() == 1 && bus.out_ready);
      check_eq("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      check_eq("out_valid", 64'(bus.out_valid), 64'(exp_v));
      if (exp_v) begin
        check_eq("out_data", 64'(bus.out_data), 64'(model_q[0].d));
        check_eq("out_last", 64'(bus.out_last), 64'(model_q[0].l));
      end else begin
        check_eq("out_last_idle", 64'(bus.out_last), 64'(0));
      end
      if (exp_v && bus.out_ready) begin
        words_seen++;
        if (model_q[0].l) lasts_seen++;
        void'(model_q.pop_front());
      end
      if (bus.in_valid && exp_rdy) begin
        for (int k = 0; k < LANES; k++) begin
          exp_t e;
          e.d = ref_word(bus.in_data[k*DATA_W +: DATA_W], bus.mode, int'(bus.scale_shift));
          e.l = bus.in_last && (k == LANES - 1);
          model_q.push_back(e);
        end
      end
    end
  end

  // Downstream ready: steady high or randomly toggled.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_group(input logic [LANES*DATA_W-1:0] d, input logic m,
                            input logic [SCALE_W-1:0] s, input logic last);
    int n = 0;
    bus.in_valid    = 1'b1;
    bus.in_data     = d;
    bus.mode        = m;
    bus.scale_shift = s;
    bus.in_last     = last;
    do begin @(negedge clk); n++; end while (!bus.in_ready && n < 300);
    if (n >= 300) check_eq("load_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.in_data     = {LANES{32'($urandom)}};
    bus.mode        = 1'($urandom);
    bus.scale_shift = SCALE_W'($urandom);
    bus.in_last     = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (bus.out_valid && n < 1000);
    if (n >= 1000) check_eq("drain_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
  endtask

  function automatic logic [LANES*DATA_W-1:0] rand_group();
    logic [LANES*DATA_W-1:0] g;
    for (int k = 0; k < LANES; k++) g[k*DATA_W +: DATA_W] = {rand_half(), rand_half()};
    return g;
  endfunction

  initial begin
    logic [LANES*DATA_W-1:0] g;
    int ws0, ls0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    bus.mode = 1'b0; bus.scale_shift = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check_eq("rst_out_data", 64'(bus.out_data), 64'(0));
    check_eq("rst_out_last", 64'(bus.out_last), 64'(0));
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;

    // Lane order with no processing.
    for (int k = 0; k < LANES; k++) g[k*DATA_W +: DATA_W] = 32'h0001_0002 * (k + 1);
    send_group(g, 1'b0, 3'd0, 1'b0);
    for (int k = 0; k < LANES; k++) begin
      @(negedge clk);
      check_eq("seq_valid", 64'(bus.out_valid), 64'(1));
      check_eq("seq_data", 64'(bus.out_data), 64'(32'h0001_0002 * (k + 1)));
      check_eq("seq_last", 64'(bus.out_last), 64'(0));
    end
    @(negedge clk);
    check_eq("seq_drop", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;

    // Swap plus rounded shift, then positive-edge and negative-edge halves.
    g = rand_group(); g[DATA_W-1:0] = 32'h0003_FFFD;
    send_group(g, 1'b1, 3'd1, 1'b0);
    @(negedge clk);
    check_eq("swap_scale", 64'(bus.out_data), 64'(32'hFFFF_0002));
    wait_idle();
    g = rand_group(); g[DATA_W-1:0] = 32'h7FFF_7FFF;
    send_group(g, 1'b0, 3'd1, 1'b0);
    @(negedge clk);
    check_eq("max_half_s1", 64'(bus.out_data), 64'(32'h4000_4000));
    wait_idle();
    g = rand_group(); g[DATA_W-1:0] = 32'h8000_8000;
    send_group(g, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    check_eq("min_half_s0", 64'(bus.out_data), 64'(32'h8000_8000));
    wait_idle();

    // Back-to-back groups, frame end on the second.
    ws0 = words_seen; ls0 = lasts_seen;
    send_group(rand_group(), 1'b0, 3'd2, 1'b0);
    send_group(rand_group(), 1'b1, 3'd3, 1'b1);
    wait_idle();
    check_eq("b2b_words", 64'(words_seen - ws0), 64'(16));
    check_eq("b2b_lasts", 64'(lasts_seen - ls0), 64'(1));

    // Random traffic under random backpressure.
    rand_ready = 1'b1;
    ws0 = words_seen;
    for (int i = 0; i < 40; i++) begin
      send_group(rand_group(), 1'($urandom), SCALE_W'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 10)) @(posedge clk);
    end
    wait_idle();
    check_eq("rand_words", 64'(words_seen - ws0), 64'(40 * LANES));
    rand_ready = 1'b0;
    @(posedge clk); #1;

    // Reset mid-group with a group still offered during reset.
    send_group(rand_group(), 1'b0, 3'd0, 1'b0);
    ws0 = words_seen;
    begin
      int n = 0;
      while (words_seen - ws0 < 3 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check_eq("rst_wait_timeout", 64'(0), 64'(1));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = rand_group(); bus.mode = 1'b0;
    bus.scale_shift = '0; bus.in_last = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_valid", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("reload_lane0", 64'(bus.out_data), 64'(bus.in_data[DATA_W-1:0]));
    wait_idle();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
